// File: rtl/light_monitor.sv
// light_monitor: conflict monitor between the intersection light controller and the lamp
// driver. Samples the street A/B light codes every cycle, checks for illegal codes,
// conflicting right-of-way, illegal colour transitions and yellow duration, and on the
// first violation latches a fault and drives a flash signal used to force flashing red.
//
// Ports:
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset
//   La, Lb       - street A/B light codes (10 green, 01 yellow, 00 red, 11 illegal)
//   fault_clr    - clear request; honoured only in FAULT with both streets red
//   fault        - sticky fault flag
//   fault_code   - cause of latched fault (0 none, 1 illegal code, 2 conflict,
//                  3 illegal transition, 4 short yellow, 5 long yellow)
//   fault_street - street that caused the fault (0 = A, 1 = B)
//   flash        - flash drive, toggles every FLASH_HALF cycles while in FAULT
module light_monitor #(
    parameter int unsigned YELLOW_MIN = 500001,
    parameter int unsigned YELLOW_MAX = 600000,
    parameter int unsigned FLASH_HALF = 25000000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] La,
    input  logic [1:0] Lb,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       fault_street,
    output logic       flash
);

    localparam logic [1:0] Red    = 2'b00;
    localparam logic [1:0] Yellow = 2'b01;
    localparam logic [1:0] Green  = 2'b10;
    localparam logic [1:0] Bad    = 2'b11;

    localparam logic [CNT_W-1:0] YMin      = CNT_W'(YELLOW_MIN);
    localparam logic [CNT_W-1:0] YMax      = CNT_W'(YELLOW_MAX);
    localparam logic [CNT_W-1:0] YSat      = CNT_W'(YELLOW_MAX + 1);
    localparam logic [CNT_W-1:0] FlashLast = CNT_W'(FLASH_HALF - 1);

    typedef enum logic [0:0] {StMonitor, StFault} state_e;

    state_e           state;
    logic [1:0]       prev_a, prev_b;
    logic [CNT_W-1:0] ycnt_a, ycnt_b;
    logic [CNT_W-1:0] flash_cnt;

    logic [2:0] code_a, code_b;
    logic       conflict;
    logic [2:0] viol_code;
    logic       viol_street;
    logic       clear_ok;

    // Per-street checks except conflict; lowest code wins within the street.
    function automatic logic [2:0] street_check(input logic [1:0]       cur,
                                                input logic [1:0]       prv,
                                                input logic [CNT_W-1:0] ycnt);
        logic [2:0] code;
        code = 3'd0;
        if (cur == Bad) begin
            code = 3'd1;
        end else if ((prv == Green  && cur == Red)    ||
                     (prv == Yellow && cur == Green)  ||
                     (prv == Red    && cur == Yellow)) begin
            code = 3'd3;
        end else if (prv == Yellow && cur == Red && ycnt < YMin) begin
            code = 3'd4;
        end else if (cur == Yellow && ycnt == YMax) begin
            code = 3'd5;
        end
        return code;
    endfunction

    function automatic logic [CNT_W-1:0] ycnt_next(input logic [1:0]       cur,
                                                   input logic [1:0]       prv,
                                                   input logic [CNT_W-1:0] ycnt);
        logic [CNT_W-1:0] nxt;
        nxt = '0;
        if (cur == Yellow) begin
            if (prv != Yellow) begin
                nxt = CNT_W'(1);
            end else if (ycnt != YSat) begin
                nxt = ycnt + CNT_W'(1);
            end else begin
                nxt = ycnt;
            end
        end
        return nxt;
    endfunction

    always_comb begin
        code_a      = street_check(La, prev_a, ycnt_a);
        code_b      = street_check(Lb, prev_b, ycnt_b);
        conflict    = (La != Red) && (Lb != Red);
        viol_code   = 3'd0;
        viol_street = 1'b0;
        // Candidates in A-first order; strict less-than keeps street A on equal codes.
        if (code_a != 3'd0) begin
            viol_code   = code_a;
            viol_street = 1'b0;
        end
        if (conflict && (viol_code == 3'd0 || viol_code > 3'd2)) begin
            viol_code   = 3'd2;
            viol_street = 1'b0;
        end
        if (code_b != 3'd0 && (viol_code == 3'd0 || code_b < viol_code)) begin
            viol_code   = code_b;
            viol_street = 1'b1;
        end
        clear_ok = fault_clr && (La == Red) && (Lb == Red);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StMonitor;
            prev_a       <= Red;
            prev_b       <= Red;
            ycnt_a       <= '0;
            ycnt_b       <= '0;
            flash_cnt    <= '0;
            fault        <= 1'b0;
            fault_code   <= 3'd0;
            fault_street <= 1'b0;
            flash        <= 1'b0;
        end else begin
            unique case (state)
                StMonitor: begin
                    prev_a <= La;
                    prev_b <= Lb;
                    ycnt_a <= ycnt_next(La, prev_a, ycnt_a);
                    ycnt_b <= ycnt_next(Lb, prev_b, ycnt_b);
                    if (viol_code != 3'd0) begin
                        state        <= StFault;
                        fault        <= 1'b1;
                        fault_code   <= viol_code;
                        fault_street <= viol_street;
                        flash_cnt    <= '0;
                        flash        <= 1'b1;
                    end
                end
                StFault: begin
                    // prev/ycnt frozen; first fault held until an all-red clear.
                    if (clear_ok) begin
                        state        <= StMonitor;
                        prev_a       <= Red;
                        prev_b       <= Red;
                        ycnt_a       <= '0;
                        ycnt_b       <= '0;
                        flash_cnt    <= '0;
                        fault        <= 1'b0;
                        fault_code   <= 3'd0;
                        fault_street <= 1'b0;
                        flash        <= 1'b0;
                    end else if (flash_cnt == FlashLast) begin
                        flash_cnt <= '0;
                        flash     <= ~flash;
                    end else begin
                        flash_cnt <= flash_cnt + CNT_W'(1);
                    end
                end
                default: state <= StMonitor;
            endcase
        end
    end

endmodule

// File: tb/tb_light_monitor.sv
// Directed self-checking bench for light_monitor with YELLOW_MIN=4, YELLOW_MAX=8,
// FLASH_HALF=3. Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_light_monitor;

    logic       clk;
    logic       rst_n;
    logic [1:0] La;
    logic [1:0] Lb;
    logic       fault_clr;
    logic       fault;
    logic [2:0] fault_code;
    logic       fault_street;
    logic       flash;

    int unsigned total;
    int unsigned passed;

    light_monitor #(
        .YELLOW_MIN(4),
        .YELLOW_MAX(8),
        .FLASH_HALF(3),
        .CNT_W     (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .La          (La),
        .Lb          (Lb),
        .fault_clr   (fault_clr),
        .fault       (fault),
        .fault_code  (fault_code),
        .fault_street(fault_street),
        .flash       (flash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic f, input logic [2:0] c,
                           input logic s, input logic fl);
        chk({tag, ".fault"}, 32'(fault), 32'(f));
        chk({tag, ".code"}, 32'(fault_code), 32'(c));
        chk({tag, ".street"}, 32'(fault_street), 32'(s));
        chk({tag, ".flash"}, 32'(flash), 32'(fl));
    endtask

    // Apply one sample and advance past the edge that samples it.
    task automatic cyc(input logic [1:0] a, input logic [1:0] b);
        La = a;
        Lb = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        La = 2'b00;
        Lb = 2'b00;
        fault_clr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic do_clear(input string tag);
        fault_clr = 1'b1;
        cyc(2'b00, 2'b00);
        fault_clr = 1'b0;
        chk_out(tag, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst_n = 1'b0;
        La = 2'b00;
        Lb = 2'b00;
        fault_clr = 1'b0;
        #12;
        chk_out("reset", 1'b0, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Normal sequence: A green 5, yellow 5, then B green, yellow 4, red.
        for (int i = 0; i < 5; i++) cyc(2'b10, 2'b00);
        for (int i = 0; i < 5; i++) cyc(2'b01, 2'b00);
        chk_out("norm_a", 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(2'b00, 2'b10);
        for (int i = 0; i < 4; i++) cyc(2'b00, 2'b01);
        cyc(2'b00, 2'b00);
        cyc(2'b00, 2'b00);
        chk_out("norm_b", 1'b0, 3'd0, 1'b0, 1'b0);

        // Conflict, then flash pattern and hold of first fault.
        cyc(2'b10, 2'b10);
        chk_out("conflict", 1'b1, 3'd2, 1'b0, 1'b1);
        cyc(2'b10, 2'b10);
        chk("flash1", 32'(flash), 32'd1);
        cyc(2'b10, 2'b10);
        chk("flash2", 32'(flash), 32'd1);
        cyc(2'b10, 2'b10);
        chk("flash3", 32'(flash), 32'd0);
        cyc(2'b00, 2'b01);
        chk("flash4", 32'(flash), 32'd0);
        cyc(2'b11, 2'b11);
        chk("flash5", 32'(flash), 32'd0);
        cyc(2'b10, 2'b10);
        chk_out("flash6_hold", 1'b1, 3'd2, 1'b0, 1'b1);
        fault_clr = 1'b1;
        cyc(2'b10, 2'b00);
        fault_clr = 1'b0;
        chk_out("clr_ignored", 1'b1, 3'd2, 1'b0, 1'b1);
        do_clear("clr_conflict");

        // Short yellow on B: 3 yellows then red.
        cyc(2'b00, 2'b10);
        cyc(2'b00, 2'b10);
        for (int i = 0; i < 3; i++) cyc(2'b00, 2'b01);
        chk("short_pre", 32'(fault), 32'd0);
        cyc(2'b00, 2'b00);
        chk_out("short_y", 1'b1, 3'd4, 1'b1, 1'b1);
        do_clear("clr_short");

        // Exactly YELLOW_MIN yellows on A then red is legal.
        cyc(2'b10, 2'b00);
        for (int i = 0; i < 4; i++) cyc(2'b01, 2'b00);
        cyc(2'b00, 2'b00);
        chk("min_ok", 32'(fault), 32'd0);

        // Exactly YELLOW_MAX yellows on B then red is legal.
        do_reset();
        cyc(2'b00, 2'b10);
        for (int i = 0; i < 8; i++) cyc(2'b00, 2'b01);
        cyc(2'b00, 2'b00);
        chk_out("max_ok", 1'b0, 3'd0, 1'b0, 1'b0);

        // Long yellow on B: fault on 9th yellow sample.
        do_reset();
        cyc(2'b00, 2'b10);
        for (int i = 0; i < 8; i++) cyc(2'b00, 2'b01);
        chk("long_pre", 32'(fault), 32'd0);
        cyc(2'b00, 2'b01);
        chk_out("long_y", 1'b1, 3'd5, 1'b1, 1'b1);
        do_clear("clr_long");

        // Illegal transition: A green -> red.
        cyc(2'b10, 2'b00);
        chk("trans_pre", 32'(fault), 32'd0);
        cyc(2'b00, 2'b00);
        chk_out("g2r", 1'b1, 3'd3, 1'b0, 1'b1);
        do_clear("clr_g2r");

        // Illegal code on A together with a conflict: code 1 wins.
        cyc(2'b11, 2'b10);
        chk_out("illegal", 1'b1, 3'd1, 1'b0, 1'b1);
        do_clear("clr_illegal");

        // B red -> yellow while A is fine: illegal transition reported on B.
        cyc(2'b00, 2'b01);
        chk_out("r2y_b", 1'b1, 3'd3, 1'b1, 1'b1);

        // Asynchronous reset mid-fault.
        cyc(2'b00, 2'b00);
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(2'b10, 2'b00);
        cyc(2'b10, 2'b00);
        for (int i = 0; i < 4; i++) cyc(2'b01, 2'b00);
        cyc(2'b00, 2'b00);
        chk_out("post_rst", 1'b0, 3'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/light_monitor.md
# light_monitor

Conflict monitor for the two-street intersection light controller. It samples the controller's 2-bit light codes for street A and street B every cycle and checks four things: legal codes, no conflicting right-of-way, legal colour sequence, and yellow duration. On the first violation it latches a fault, reports the cause, and drives a flash signal that the downstream lamp driver uses to force flashing red. It sits between the light controller outputs and the lamp driver.

## Interface
- `YELLOW_MIN`, default 500001: minimum consecutive yellow cycles required before red.
- `YELLOW_MAX`, default 600000: maximum consecutive yellow cycles allowed.
- `FLASH_HALF`, default 25000000: flash half-period, in cycles.
- `CNT_W`, default 32: counter width. Must hold `max(YELLOW_MAX+1, FLASH_HALF)`.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `La` in 2: street A light code. 2'b10 = green, 2'b01 = yellow, 2'b00 = red, 2'b11 = illegal.
- `Lb` in 2: street B light code, same encoding as `La`.
- `fault_clr` in 1: request to clear a latched fault.
- `fault` out 1: sticky fault flag.
- `fault_code` out 3: cause of the latched fault. 0 = none.
- `fault_street` out 1: street that caused the fault. 0 = A, 1 = B.
- `flash` out 1: flash drive. Toggles only while in FAULT.

## Operation
- State machine has two states: MONITOR and FAULT.
- Per-street registers: `prev` (last sampled code) and `ycnt` (consecutive yellow samples, saturates at YELLOW_MAX+1).
- Checks run every MONITOR cycle on the current inputs against `prev`. Lower code number wins when several fire:
  - Code 1, illegal code: input equals 2'b11.
  - Code 2, conflict: `La != 00` and `Lb != 00`. Reported with `fault_street` = 0.
  - Code 3, illegal transition. Legal transitions are hold, red→green, green→yellow and yellow→red. Illegal: green→red, yellow→green, red→yellow.
  - Code 4, short yellow: yellow→red while `ycnt < YELLOW_MIN`.
  - Code 5, long yellow: yellow sampled while `ycnt == YELLOW_MAX`, i.e. on the (YELLOW_MAX+1)th consecutive yellow sample.
- Street priority: if both streets violate with the same code, street A is reported.
- `ycnt` update in MONITOR:
  - Set to 1 when the current sample is yellow and `prev` is not yellow.
  - Incremented (saturating) while yellow persists.
  - Cleared to 0 when the sample is not yellow.
- `prev` is loaded with the current input each MONITOR cycle.
- Any violation moves MONITOR to FAULT. On that transition:
  - `fault` is set to 1.
  - `fault_code` and `fault_street` are latched.
  - The flash counter is cleared and `flash` is set to 1.
- In FAULT:
  - Checks are disabled, and the first fault is held (later violations never overwrite it).
  - `prev` and `ycnt` are frozen.
  - The flash counter counts 0..FLASH_HALF-1. On wrap, `flash` toggles.
- Leaving FAULT requires `fault_clr` = 1 with `La` = 00 and `Lb` = 00 in the same cycle. On that cycle's edge:
  - State returns to MONITOR.
  - `fault`, `fault_code`, `fault_street` and `flash` are cleared to 0.
  - `prev` is set to red for both streets.
  - `ycnt` is cleared to 0.
- `fault_clr` with any non-red input is ignored. `fault_clr` in MONITOR has no effect.

## Timing
- Reset (`rst_n` low, any time, including mid-fault or mid-yellow):
  - State goes to MONITOR.
  - `prev` = 00 for both streets.
  - `ycnt` = 0, flash counter = 0.
  - All outputs go to 0: `fault`, `fault_code`, `fault_street`, `flash`.
- The first sample after reset is checked against red. A controller starting at A green, B red is therefore legal.
- Latency: a violation sampled at edge N shows `fault` = 1 and a valid code after edge N. No combinational path from inputs to outputs.
- Yellow-length boundaries:
  - With YELLOW_MIN = 4, red after exactly 4 yellow samples is legal; red after 3 yellow samples is code 4.
  - The yellow sample at `ycnt` = YELLOW_MAX is code 5. Exactly YELLOW_MAX yellow samples followed by red is legal.
- A clear and a new violation in the same cycle cannot occur, because clear requires all-red. The first MONITOR check runs on the cycle after the clear.
- Flash timing: first toggle FLASH_HALF cycles after fault entry, then every FLASH_HALF cycles.

## Test plan
Bench parameters: YELLOW_MIN = 4, YELLOW_MAX = 8, FLASH_HALF = 3.

- Normal sequence. A: 10 for 5 cycles, then 01 for 5, then 00; B: 00, then 10, 01 for 4, 00 → `fault` stays 0, `fault_code` stays 0.
- Conflict. `La` = 10 and `Lb` = 10 in one cycle → next cycle `fault` = 1, `fault_code` = 2, `fault_street` = 0.
- Yellow length on street B:
  - 3 yellow samples then red → `fault_code` = 4, `fault_street` = 1.
  - After reset, 9 yellow samples → fault at the 9th, `fault_code` = 5.
- Illegal inputs:
  - `La` green→red → code 3.
  - `La` = 11 together with a conflict → code 1, street 0, since illegal code has higher priority.
- Fault hold and clear:
  - In FAULT, `flash` = 1,1,1,0,0,0,1 on successive cycles.
  - `fault_clr` with `La` = 10 → remains in FAULT.
  - `fault_clr` with both inputs 00 → all outputs 0 next cycle.
- Reset mid-fault. Assert `rst_n` = 0 asynchronously between edges → outputs go to 0 immediately. After release, a red→green sequence on A is accepted.
